// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction-memory read port, decode-side
// instruction handshake and the control inputs from PC/branch logic.
//
// Handshake rule for the decode side: a word transfers on a rising edge
// where inst_valid && inst_ready are both high. inst_valid never depends on
// inst_ready in the same cycle, and once asserted it stays asserted with
// stable inst_out/inst_pc until the transfer happens or a redirect/reset
// flushes the buffer.
interface fetch_sequencer_if;
   logic        halt;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;

   // Fetch sequencer side
   modport master (
      input  halt,
      input  redirect_valid,
      input  redirect_pc,
      input  mem_rdata,
      input  inst_ready,
      output mem_en,
      output mem_addr,
      output inst_valid,
      output inst_out,
      output inst_pc
   );

   // Environment side: control logic, instruction memory and decode
   modport slave (
      output halt,
      output redirect_valid,
      output redirect_pc,
      output mem_rdata,
      output inst_ready,
      input  mem_en,
      input  mem_addr,
      input  inst_valid,
      input  inst_out,
      input  inst_pc
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer. Owns the fetch PC, issues reads to a
// 1-cycle-latency instruction memory and buffers returned words together
// with their PCs in a small FIFO for decode. A request is only issued when
// the buffer has room for it counting the word still in flight, so the
// returning word always has a slot and nothing is ever dropped.
// Redirects flush the buffer and discard any response still in flight.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input logic             clk,
   input logic             rst,
   fetch_sequencer_if.master bus
);

   localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   inflight_pc;
   logic          inflight;
   logic [AW:0]   count;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [31:0]   word_mem [FIFO_DEPTH];
   logic [31:0]   pc_mem   [FIFO_DEPTH];

   logic [AW+1:0] credit_used;
   logic          issue;
   logic          push;
   logic          pop;

   // Slots already claimed: buffered words plus the one coming back next cycle
   assign credit_used = {1'b0, count} + (AW+2)'(inflight);

   // New request only when it is guaranteed a buffer slot on return
   assign issue = !rst && !bus.halt && !bus.redirect_valid && (credit_used < DEPTH_W);

   // A returning word is kept unless a redirect discards it this cycle
   assign push = inflight && !bus.redirect_valid;

   // Pop on handshake; never when empty
   assign pop = (count != '0) && bus.inst_ready;

   assign bus.mem_en     = issue;
   assign bus.mem_addr   = fetch_pc;
   assign bus.inst_valid = (count != '0);
   assign bus.inst_out   = word_mem[rd_ptr];
   assign bus.inst_pc    = pc_mem[rd_ptr];

   // Fetch PC, in-flight tracking and FIFO pointers/occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= RESET_PC;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else if (bus.redirect_valid) begin
         // Restart at the aligned target; whatever was buffered or in flight is stale
         fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
         inflight <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Buffer storage: returned word and the PC it was fetched from
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            word_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else if (push) begin
         word_mem[wr_ptr] <= bus.mem_rdata;
         pc_mem[wr_ptr]   <= inflight_pc;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer. Inputs change on the falling edge; outputs are
// compared 1 ns later against a queue-level model of the fetch stream.
module tb_fetch_sequencer;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int          FIFO_DEPTH = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_sequencer_if bus ();

   fetch_sequencer #(
      .RESET_PC  (RESET_PC),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   // ---------------- scoreboard / model ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];      // PCs expected in the buffer, head first
   bit          m_pend;        // a request was issued last cycle
   logic [31:0] m_pend_pc;
   logic [31:0] m_fetch_pc;
   bit          prev_en;       // memory model: request seen last cycle
   logic [31:0] prev_addr;

   function automatic logic [31:0] word_fn(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_pend     = 1'b0;
      m_pend_pc  = RESET_PC;
      m_fetch_pc = RESET_PC;
   endtask

   // ---------------- driver ----------------
   task automatic drive_cycle(input bit r, input bit h, input bit rv,
                              input logic [31:0] rpc, input bit rdy);
      bit e_en;
      @(negedge clk);
      rst                = r;
      bus.halt           = h;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.inst_ready     = rdy;
      bus.mem_rdata      = prev_en ? word_fn(prev_addr) : 32'($urandom());
      if (r) model_reset();
      #1;
      e_en = !r && !h && !rv && ((exp_q.size() + int'(m_pend)) < FIFO_DEPTH);
      check_eq("mem_en", 32'(bus.mem_en), 32'(e_en));
      check_eq("mem_addr", bus.mem_addr, m_fetch_pc);
      check_eq("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check_eq("inst_pc", bus.inst_pc, exp_q[0]);
         check_eq("inst_out", bus.inst_out, word_fn(exp_q[0]));
      end else if (r) begin
         check_eq("rst_inst_pc", bus.inst_pc, 32'h0);
         check_eq("rst_inst_out", bus.inst_out, 32'h0);
      end
      prev_en   = bus.mem_en;
      prev_addr = bus.mem_addr;
      // Advance model to the state after the coming rising edge
      if (!r) begin
         if (rv) begin
            exp_q.delete();
            m_pend     = 1'b0;
            m_fetch_pc = {rpc[31:2], 2'b00};
         end else begin
            if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
            if (m_pend) exp_q.push_back(m_pend_pc);
            m_pend    = e_en;
            m_pend_pc = m_fetch_pc;
            if (e_en) m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
   endtask

   task automatic stream(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rpc;
      bit          r, h, rv, rdy;
      rst                = 1'b1;
      bus.halt           = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.inst_ready     = 1'b0;
      bus.mem_rdata      = 32'h0;
      prev_en            = 1'b0;
      prev_addr          = 32'h0;
      model_reset();

      // Reset state, then plain streaming
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      stream(12);

      // Backpressure: fill, hold, then drain in order
      for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      stream(8);

      // Redirects: plain target, unaligned target, wrap-around target
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
      stream(6);
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0203, 1'b1);
      stream(6);
      drive_cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
      stream(8);

      // Back-to-back redirects: last one wins
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b1);
      drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0800, 1'b1);
      stream(6);

      // Halt mid-stream, then redirect while halted
      for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      stream(4);
      drive_cycle(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1);
      drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      stream(5);

      // Reset mid-stream
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      stream(6);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         r   = ($urandom_range(0, 199) == 0);
         h   = ($urandom_range(0, 4) == 0);
         rv  = ($urandom_range(0, 19) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else                           rpc = 32'($urandom_range(0, 4095));
         drive_cycle(r, h, rv, rpc, rdy);
      end
      stream(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
